// File: rtl/mem_access_stage.sv
// MEM stage of a 5-stage MIPS pipeline.
// Issues lw/lh/lhu/lb/sw accesses on a req/ack data-memory bus, stalls the
// upstream pipeline while an access is outstanding, extends load data and
// registers the MEM/WB fields for the writeback stage.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        MemToReg_in,
  input  logic [1:0]  load_mode_in,
  input  logic [31:0] aluResult_in,
  input  logic [31:0] rt_in,
  input  logic [4:0]  writebackDestination_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] memData_out,
  output logic [31:0] aluResult_out,
  output logic [4:0]  writebackDestination_out,
  output logic        fault_out
);

  localparam logic [7:0] TMO_LIMIT = 8'(ACK_TIMEOUT);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;

  // Copies of the EX/MEM fields taken on entry to WAIT_ACK; the upstream
  // inputs are not looked at again until the access finishes.
  logic        lat_regwrite;
  logic        lat_memtoreg;
  logic        lat_we;
  logic [1:0]  lat_mode;
  logic [31:0] lat_alu;
  logic [4:0]  lat_dest;

  logic        access_in;
  logic        aligned;
  logic        timeout_hit;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;

  assign access_in = MemRead_in | MemWrite_in;

  // Stores are always word accesses; loads are checked against their width.
  always_comb begin
    aligned = 1'b1;
    if (MemWrite_in) begin
      aligned = (aluResult_in[1:0] == 2'b00);
    end else begin
      case (load_mode_in)
        2'b00:   aligned = (aluResult_in[1:0] == 2'b00);
        2'b01,
        2'b10:   aligned = (aluResult_in[0] == 1'b0);
        default: aligned = 1'b1;
      endcase
    end
  end

  assign timeout_hit = (state == WAIT_ACK) && !dmem_ack && (tmo_cnt == TMO_LIMIT);

  // Stall on an aligned access entering the stage and for every WAIT_ACK
  // cycle that neither completes nor aborts the access.
  always_comb begin
    mem_stall = 1'b0;
    if (state == IDLE) begin
      mem_stall = access_in & aligned;
    end else begin
      mem_stall = !dmem_ack && !timeout_hit;
    end
  end

  // Little-endian lane selection from the latched byte offset, then extension.
  always_comb begin
    half_sel = lat_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_alu[1:0])
      2'b00:   byte_sel = dmem_rdata[7:0];
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    case (lat_mode)
      2'b00:   load_data = dmem_rdata;
      2'b01:   load_data = {{16{half_sel[15]}}, half_sel};
      2'b10:   load_data = {16'h0000, half_sel};
      default: load_data = {{24{byte_sel[7]}}, byte_sel};
    endcase
  end

  // Access FSM with registered bus and MEM/WB outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      tmo_cnt                  <= 8'd0;
      dmem_req                 <= 1'b0;
      dmem_we                  <= 1'b0;
      dmem_addr                <= 32'd0;
      dmem_wdata               <= 32'd0;
      lat_regwrite             <= 1'b0;
      lat_memtoreg             <= 1'b0;
      lat_we                   <= 1'b0;
      lat_mode                 <= 2'b00;
      lat_alu                  <= 32'd0;
      lat_dest                 <= 5'd0;
      RegWrite_out             <= 1'b0;
      MemToReg_out             <= 1'b0;
      memData_out              <= 32'd0;
      aluResult_out            <= 32'd0;
      writebackDestination_out <= 5'd0;
      fault_out                <= 1'b0;
    end else begin
      fault_out <= 1'b0;
      case (state)
        IDLE: begin
          MemToReg_out             <= MemToReg_in;
          aluResult_out            <= aluResult_in;
          writebackDestination_out <= writebackDestination_in;
          memData_out              <= 32'd0;
          if (!access_in) begin
            RegWrite_out <= RegWrite_in;
          end else if (!aligned) begin
            // Misaligned: no bus cycle, suppress the register write.
            RegWrite_out <= 1'b0;
            fault_out    <= 1'b1;
          end else begin
            // Aligned: launch the bus access and emit a bubble.
            RegWrite_out <= 1'b0;
            lat_regwrite <= RegWrite_in;
            lat_memtoreg <= MemToReg_in;
            lat_we       <= MemWrite_in;
            lat_mode     <= load_mode_in;
            lat_alu      <= aluResult_in;
            lat_dest     <= writebackDestination_in;
            dmem_req     <= 1'b1;
            dmem_we      <= MemWrite_in;
            dmem_addr    <= {aluResult_in[31:2], 2'b00};
            dmem_wdata   <= rt_in;
            tmo_cnt      <= 8'd0;
            state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (dmem_ack) begin
            dmem_req                 <= 1'b0;
            dmem_we                  <= 1'b0;
            tmo_cnt                  <= 8'd0;
            state                    <= IDLE;
            RegWrite_out             <= lat_regwrite & ~lat_we;
            MemToReg_out             <= lat_memtoreg;
            aluResult_out            <= lat_alu;
            writebackDestination_out <= lat_dest;
            memData_out              <= lat_we ? 32'd0 : load_data;
          end else if (timeout_hit) begin
            // Abort; any ack that shows up later lands in IDLE and is ignored.
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            tmo_cnt      <= 8'd0;
            state        <= IDLE;
            RegWrite_out <= 1'b0;
            memData_out  <= 32'd0;
            fault_out    <= 1'b1;
          end else begin
            tmo_cnt      <= tmo_cnt + 8'd1;
            RegWrite_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite_in = 1'b0, MemWrite_in = 1'b0, MemRead_in = 1'b0, MemToReg_in = 1'b0;
  logic [1:0]  load_mode_in = 2'b00;
  logic [31:0] aluResult_in = 32'd0, rt_in = 32'd0;
  logic [4:0]  writebackDestination_in = 5'd0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;
  logic        mem_stall;
  logic        RegWrite_out, MemToReg_out;
  logic [31:0] memData_out, aluResult_out;
  logic [4:0]  writebackDestination_out;
  logic        fault_out;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.ACK_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in), .load_mode_in(load_mode_in), .aluResult_in(aluResult_in),
    .rt_in(rt_in), .writebackDestination_in(writebackDestination_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .memData_out(memData_out),
    .aluResult_out(aluResult_out), .writebackDestination_out(writebackDestination_out),
    .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWrite_in = 1'b0; MemWrite_in = 1'b0; MemRead_in = 1'b0; MemToReg_in = 1'b0;
    load_mode_in = 2'b00; aluResult_in = 32'd0; rt_in = 32'd0; writebackDestination_in = 5'd0;
  endtask

  // Drives one aligned access, acking after 'waits' idle WAIT_ACK cycles.
  // Reports the number of stalled cycles, bubbles broken, and bus cycles that
  // deviated from the expected request.
  task automatic run_access(input logic we, input logic [1:0] mode, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic regw, input logic m2r,
                            input logic [4:0] dest, input logic [31:0] rdata, input int waits,
                            input logic [31:0] exp_addr,
                            output int stall_cycles, output int bad_bubbles, output int bad_bus);
    stall_cycles = 0; bad_bubbles = 0; bad_bus = 0;
    MemWrite_in = we; MemRead_in = ~we; load_mode_in = mode; aluResult_in = addr;
    rt_in = wdata; RegWrite_in = regw; MemToReg_in = m2r; writebackDestination_in = dest;
    #1;
    if (mem_stall === 1'b1) stall_cycles++;
    step();
    for (int i = 0; i < waits; i++) begin
      if (RegWrite_out !== 1'b0) bad_bubbles++;
      if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_we !== we ||
          (we && dmem_wdata !== wdata)) bad_bus++;
      if (mem_stall === 1'b1) stall_cycles++;
      step();
    end
    if (RegWrite_out !== 1'b0) bad_bubbles++;
    if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_we !== we ||
        (we && dmem_wdata !== wdata)) bad_bus++;
    dmem_ack = 1'b1; dmem_rdata = rdata;
    #1;
    if (mem_stall === 1'b1) stall_cycles++;
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", dmem_req); end
    checks++; if (dmem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", dmem_addr); end
    checks++; if (RegWrite_out !== 1'b0 || fault_out !== 1'b0 || memData_out !== 32'd0)
      begin errors++; $display("FAIL reset_outs got rw=%b f=%b md=%h want 0", RegWrite_out, fault_out, memData_out); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mem_stall); end
    rst_n = 1'b1;
    step();
    $display("reset done");
  endtask

  task automatic test_non_mem();
    RegWrite_in = 1'b1; aluResult_in = 32'h0000_1234; writebackDestination_in = 5'd5;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL nonmem_stall got %b want 0", mem_stall); end
    step();
    clear_inputs();
    checks++; if (RegWrite_out !== 1'b1 || aluResult_out !== 32'h1234 || writebackDestination_out !== 5'd5 || memData_out !== 32'd0)
      begin errors++; $display("FAIL nonmem_out got rw=%b alu=%h d=%0d md=%h want 1 1234 5 0",
                                RegWrite_out, aluResult_out, writebackDestination_out, memData_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL nonmem_req got %b want 0", dmem_req); end
    $display("non-mem op: alu=%h dest=%0d", aluResult_out, writebackDestination_out);
  endtask

  task automatic test_lw();
    int sc, bb, bus;
    run_access(1'b0, 2'b00, 32'h100, 32'd0, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 3, 32'h100, sc, bb, bus);
    checks++; if (sc != 4) begin errors++; $display("FAIL lw_stall_cycles got %0d want 4", sc); end
    checks++; if (bb != 0) begin errors++; $display("FAIL lw_bubble got %0d bad want 0", bb); end
    checks++; if (bus != 0) begin errors++; $display("FAIL lw_bus got %0d bad want 0", bus); end
    checks++; if (memData_out !== 32'hDEAD_BEEF || RegWrite_out !== 1'b1 || MemToReg_out !== 1'b1 || writebackDestination_out !== 5'd7)
      begin errors++; $display("FAIL lw_result got md=%h rw=%b m2r=%b d=%0d want deadbeef 1 1 7",
                                memData_out, RegWrite_out, MemToReg_out, writebackDestination_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_req_drop got %b want 0", dmem_req); end
    $display("lw 0x100: data=%h stall=%0d", memData_out, sc);
  endtask

  task automatic test_load_extract();
    logic [1:0]  modes [4] = '{2'b11, 2'b11, 2'b01, 2'b10};
    logic [31:0] addrs [4] = '{32'h103, 32'h101, 32'h102, 32'h102};
    logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF};
    int sc, bb, bus;
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, modes[i], addrs[i], 32'd0, 1'b1, 1'b1, 5'd9, 32'h80FF_7F01, 0, 32'h100, sc, bb, bus);
      checks++; if (memData_out !== exps[i])
        begin errors++; $display("FAIL extract_%0d got %h want %h", i, memData_out, exps[i]); end
      checks++; if (sc != 1 || bus != 0 || RegWrite_out !== 1'b1)
        begin errors++; $display("FAIL extract_lat_%0d got stall=%0d bus=%0d rw=%b want 1 0 1", i, sc, bus, RegWrite_out); end
      $display("load mode=%b addr=%h data=%h", modes[i], addrs[i], memData_out);
    end
  endtask

  task automatic test_sw();
    int sc, bb, bus;
    run_access(1'b1, 2'b00, 32'h200, 32'h0BAD_F00D, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 2, 32'h200, sc, bb, bus);
    checks++; if (bus != 0) begin errors++; $display("FAIL sw_bus got %0d bad want 0", bus); end
    checks++; if (sc != 3) begin errors++; $display("FAIL sw_stall_cycles got %0d want 3", sc); end
    checks++; if (RegWrite_out !== 1'b0 || memData_out !== 32'd0)
      begin errors++; $display("FAIL sw_result got rw=%b md=%h want 0 0", RegWrite_out, memData_out); end
    $display("sw 0x200: stall=%0d", sc);
  endtask

  task automatic test_misaligned();
    MemRead_in = 1'b1; RegWrite_in = 1'b1; load_mode_in = 2'b00; aluResult_in = 32'h102;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b want 0", mem_stall); end
    step();
    clear_inputs();
    checks++; if (dmem_req !== 1'b0 || fault_out !== 1'b1 || RegWrite_out !== 1'b0)
      begin errors++; $display("FAIL mis_out got req=%b f=%b rw=%b want 0 1 0", dmem_req, fault_out, RegWrite_out); end
    step();
    checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b want 0", fault_out); end
    $display("misaligned lw 0x102: fault pulsed");
  endtask

  task automatic test_timeout();
    int cyc = 0;
    MemRead_in = 1'b1; RegWrite_in = 1'b1; load_mode_in = 2'b00; aluResult_in = 32'h300;
    #1;
    while (mem_stall === 1'b1 && cyc < 400) begin
      cyc++;
      step();
    end
    checks++; if (cyc != 256) begin errors++; $display("FAIL tmo_stall_cycles got %0d want 256", cyc); end
    step();
    clear_inputs();
    checks++; if (dmem_req !== 1'b0 || fault_out !== 1'b1 || RegWrite_out !== 1'b0)
      begin errors++; $display("FAIL tmo_abort got req=%b f=%b rw=%b want 0 1 0", dmem_req, fault_out, RegWrite_out); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_ack = 1'b0;
    checks++; if (dmem_req !== 1'b0 || fault_out !== 1'b0 || memData_out !== 32'd0 || RegWrite_out !== 1'b0)
      begin errors++; $display("FAIL tmo_late_ack got req=%b f=%b md=%h rw=%b want 0 0 0 0",
                                dmem_req, fault_out, memData_out, RegWrite_out); end
    $display("timeout: stalled %0d cycles", cyc);
  endtask

  task automatic test_reset_mid();
    MemRead_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'b1; aluResult_in = 32'h400;
    step();
    step();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", dmem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || dmem_addr !== 32'd0 || RegWrite_out !== 1'b0 || memData_out !== 32'd0 || fault_out !== 1'b0)
      begin errors++; $display("FAIL rstmid_outs got req=%b a=%h rw=%b md=%h f=%b want all 0",
                                dmem_req, dmem_addr, RegWrite_out, memData_out, fault_out); end
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL rstmid_after got st=%b req=%b want 0 0", mem_stall, dmem_req); end
    $display("reset mid-access: outputs cleared");
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_lw();
    test_load_extract();
    test_sw();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
